// File: rtl/decade_digit_capture_if.sv
// Bundle between the ripple decade counter pins and the digit capture block.
// master drives the counter pins; slave (the capture block) returns the digits and flags.
interface decade_digit_capture_if;
  logic       q1;
  logic       q2;
  logic       q3;
  logic       q4;
  logic       z;
  logic [3:0] units;
  logic [3:0] tens;
  logic       dvld;
  logic       carry;
  logic       ovf;
  logic       err;
  logic       zmiss;
  logic [6:0] seg;

  modport master (
    output q1, q2, q3, q4, z,
    input  units, tens, dvld, carry, ovf, err, zmiss, seg
  );

  modport slave (
    input  q1, q2, q3, q4, z,
    output units, tens, dvld, carry, ovf, err, zmiss, seg
  );
endinterface

// File: rtl/decade_digit_capture.sv
// Synchronises a ripple decade counter, debounces its code into a BCD units digit and counts wraps as tens.
// Define SEG_DECODE_EN to build the registered 7-segment decoder; otherwise seg is tied to zero.
module decade_digit_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE_CYC  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  decade_digit_capture_if.slave bus
);

  localparam logic [3:0] SETTLE_LIM = 4'(SETTLE_CYC);

  typedef enum logic [0:0] {
    ST_STABLE = 1'b0,
    ST_SETTLE = 1'b1
  } state_e;

  logic [4:0] sync_q [SYNC_STAGES];
  logic [3:0] raw_s;
  logic       zs_s;
  state_e     state_q;
  logic [3:0] cand_q;
  logic [3:0] cnt_q;
  logic [3:0] units_q;
  logic [3:0] tens_q;
  logic [3:0] tens_d;
  logic       tens_wrap_s;
  logic       dvld_q;
  logic       carry_q;
  logic       ovf_q;
  logic       err_q;
  logic       zmiss_q;
  logic       z_seen_q;

`ifdef SEG_DECODE_EN
  logic [6:0] seg_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h00;
    endcase
  endfunction
`endif

  // Synchroniser chain; bit 4 carries z alongside the four code bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 5'd0;
    end else begin
      sync_q[0] <= {bus.z, bus.q4, bus.q3, bus.q2, bus.q1};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign raw_s = sync_q[SYNC_STAGES-1][3:0];
  assign zs_s  = sync_q[SYNC_STAGES-1][4];

  // Next tens value on a 9->0 units commit.
  always_comb begin
    tens_wrap_s = (tens_q == 4'd9);
    if (tens_wrap_s) begin
      tens_d = 4'd0;
    end else begin
      tens_d = tens_q + 4'd1;
    end
  end

  // Settle FSM with commit logic; every output is a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_STABLE;
      cand_q   <= 4'd0;
      cnt_q    <= 4'd0;
      units_q  <= 4'd0;
      tens_q   <= 4'd0;
      dvld_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      zmiss_q  <= 1'b0;
      z_seen_q <= 1'b0;
`ifdef SEG_DECODE_EN
      seg_q    <= 7'h3F;
`endif
    end else begin
      dvld_q  <= 1'b0;
      carry_q <= 1'b0;
      if (zs_s && (units_q == 4'd9)) z_seen_q <= 1'b1;
      case (state_q)
        ST_STABLE: begin
          if (raw_s != units_q) begin
            cand_q  <= raw_s;
            cnt_q   <= 4'd1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (raw_s != cand_q) begin
            cand_q <= raw_s;
            cnt_q  <= 4'd1;
          end else if (cnt_q < SETTLE_LIM) begin
            cnt_q <= cnt_q + 4'd1;
          end else begin
            // Commit point; a code that returned to units is silently dropped.
            state_q  <= ST_STABLE;
            z_seen_q <= 1'b0;
            if (cand_q != units_q) begin
              if (cand_q > 4'd9) begin
                err_q <= 1'b1;
              end else begin
                units_q <= cand_q;
                dvld_q  <= 1'b1;
`ifdef SEG_DECODE_EN
                seg_q   <= seg_decode(cand_q);
`endif
                if ((cand_q == 4'd0) && (units_q == 4'd9)) begin
                  carry_q <= 1'b1;
                  tens_q  <= tens_d;
                  if (tens_wrap_s) ovf_q <= 1'b1;
                  if (!z_seen_q) zmiss_q <= 1'b1;
                end
              end
            end
          end
        end
        default: state_q <= ST_STABLE;
      endcase
    end
  end

  assign bus.units = units_q;
  assign bus.tens  = tens_q;
  assign bus.dvld  = dvld_q;
  assign bus.carry = carry_q;
  assign bus.ovf   = ovf_q;
  assign bus.err   = err_q;
  assign bus.zmiss = zmiss_q;
`ifdef SEG_DECODE_EN
  assign bus.seg   = seg_q;
`else
  assign bus.seg   = 7'h00;
`endif

endmodule

// File: tb/tb_decade_digit_capture.sv
// Bench for decade_digit_capture: run-length reference model checked every cycle, plus directed literal checks.
module tb_decade_digit_capture;
  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
`ifdef SEG_DECODE_EN
  localparam bit SEG_ON = 1'b1;
`else
  localparam bit SEG_ON = 1'b0;
`endif
  localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   passed = 0;
  int   dvld_cnt = 0;
  int   carry_cnt = 0;
  int   lone_carry = 0;

  decade_digit_capture_if bus();

  decade_digit_capture #(.SYNC_STAGES(SYNC), .SETTLE_CYC(SETTLE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] d);
    if (SEG_ON && d <= 4'd9) return SEG_TAB[d];
    return 7'h00;
  endfunction

  // Reference model: a code is committed once it has been seen on SETTLE+1
  // consecutive synchronised samples; the synchroniser is a plain delay queue.
  logic [4:0] pipe [$];
  logic       model_valid = 1'b0;
  logic [3:0] prev_raw;
  int         run;
  logic [3:0] m_units, m_tens;
  logic       m_dvld, m_carry, m_ovf, m_err, m_zmiss, m_zseen;

  always @(posedge clk) begin : model
    logic [4:0] cur;
    if (!rst_n) begin
      pipe = {};
      for (int i = 0; i < SYNC; i++) pipe.push_back(5'd0);
      prev_raw = 4'd0; run = 0;
      m_units = 4'd0; m_tens = 4'd0; m_dvld = 1'b0; m_carry = 1'b0;
      m_ovf = 1'b0; m_err = 1'b0; m_zmiss = 1'b0; m_zseen = 1'b0;
      model_valid = 1'b1;
    end else begin
      cur = pipe.pop_front();
      pipe.push_back({bus.z, bus.q4, bus.q3, bus.q2, bus.q1});
      m_dvld = 1'b0; m_carry = 1'b0;
      if (cur[3:0] == prev_raw) run++; else run = 1;
      prev_raw = cur[3:0];
      if (run == SETTLE + 1) begin
        if (cur[3:0] > 4'd9) m_err = 1'b1;
        else if (cur[3:0] != m_units) begin
          m_dvld = 1'b1;
          if (cur[3:0] == 4'd0 && m_units == 4'd9) begin
            m_carry = 1'b1;
            if (!m_zseen) m_zmiss = 1'b1;
            if (m_tens == 4'd9) begin m_tens = 4'd0; m_ovf = 1'b1; end
            else m_tens = m_tens + 4'd1;
          end
          m_units = cur[3:0];
        end
        m_zseen = 1'b0;
      end else if (cur[4] && m_units == 4'd9) begin
        m_zseen = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      check("units", 32'(bus.units), 32'(m_units));
      check("tens",  32'(bus.tens),  32'(m_tens));
      check("dvld",  32'(bus.dvld),  32'(m_dvld));
      check("carry", 32'(bus.carry), 32'(m_carry));
      check("ovf",   32'(bus.ovf),   32'(m_ovf));
      check("err",   32'(bus.err),   32'(m_err));
      check("zmiss", 32'(bus.zmiss), 32'(m_zmiss));
      check("seg",   32'(bus.seg),   32'(exp_seg(m_units)));
    end
    if (bus.dvld === 1'b1) dvld_cnt++;
    if (bus.carry === 1'b1) carry_cnt++;
    if (bus.carry === 1'b1 && bus.dvld !== 1'b1) lone_carry++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_q(input logic [3:0] v);
    {bus.q4, bus.q3, bus.q2, bus.q1} = v;
  endtask

  task automatic ramp(input bit with_z);
    for (int v = 0; v <= 9; v++) begin
      set_q(4'(v));
      if (v == 9 && with_z) begin
        hold(2); bus.z = 1'b1; hold(4); bus.z = 1'b0; hold(4);
      end else begin
        hold(10);
      end
    end
    set_q(4'd0);
    hold(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, c0, lat;
    rst_n = 1'b0; bus.z = 1'b0; set_q(4'd0);
    hold(3);
    check("rst_units", 32'(bus.units), 32'd0);
    check("rst_tens",  32'(bus.tens),  32'd0);
    check("rst_flags", 32'({bus.dvld, bus.carry, bus.err, bus.zmiss, bus.ovf}), 32'd0);
    check("rst_seg",   32'(bus.seg), SEG_ON ? 32'h3F : 32'h00);
    rst_n = 1'b1;
    hold(4);

    // Latency of a single step 0->1.
    set_q(4'd1);
    @(posedge clk);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (bus.dvld === 1'b1) begin lat = n; break; end
    end
    check("latency", 32'(lat), 32'd6);
    @(negedge clk);
    hold(14);
    check("step_units", 32'(bus.units), 32'd1);
    check("step_seg",   32'(bus.seg), SEG_ON ? 32'h06 : 32'h00);

    // One-cycle glitch 3->2->3 must not produce a commit.
    set_q(4'd3); hold(12);
    d0 = dvld_cnt;
    set_q(4'd2); hold(1);
    set_q(4'd3); hold(12);
    check("glitch_dvld", 32'(dvld_cnt - d0), 32'd0);
    set_q(4'd7); hold(12);
    check("seven_dvld",  32'(dvld_cnt - d0), 32'd1);
    check("seven_units", 32'(bus.units), 32'd7);

    // Ramp with z, then without z.
    c0 = carry_cnt;
    ramp(1'b1);
    check("ramp_z_carry", 32'(carry_cnt - c0), 32'd1);
    check("ramp_z_tens",  32'(bus.tens),  32'd1);
    check("ramp_z_zmiss", 32'(bus.zmiss), 32'd0);
    ramp(1'b0);
    check("ramp_nz_tens",  32'(bus.tens),  32'd2);
    check("ramp_nz_zmiss", 32'(bus.zmiss), 32'd1);
    check("lone_carry",    32'(lone_carry), 32'd0);

    // Ten ramps from reset wrap tens and set ovf.
    @(negedge clk); rst_n = 1'b0; hold(2); rst_n = 1'b1; hold(4);
    for (int r = 0; r < 10; r++) ramp(1'b1);
    check("wrap_tens",  32'(bus.tens),  32'd0);
    check("wrap_ovf",   32'(bus.ovf),   32'd1);
    check("wrap_zmiss", 32'(bus.zmiss), 32'd0);

    // Illegal code 12 flags err without touching units.
    d0 = dvld_cnt;
    set_q(4'd12); hold(10);
    check("bad_err",   32'(bus.err),   32'd1);
    check("bad_units", 32'(bus.units), 32'd0);
    check("bad_dvld",  32'(dvld_cnt - d0), 32'd0);

    // Reset while settling (cnt=2) discards the candidate.
    set_q(4'd0); rst_n = 1'b0; hold(2); rst_n = 1'b1; hold(4);
    d0 = dvld_cnt;
    set_q(4'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0; set_q(4'd0);
    @(negedge clk);
    check("midrst_units", 32'(bus.units), 32'd0);
    check("midrst_dvld",  32'(bus.dvld),  32'd0);
    rst_n = 1'b1;
    hold(12);
    check("midrst_nodvld", 32'(dvld_cnt - d0), 32'd0);
    check("midrst_after",  32'(bus.units), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
